// File: rtl/cache_pipe_miss_stage.sv
// Resolve stage of the pipelined L1 cache: registers the tag-stage result, answers hits
// in one cycle and runs write-back / line-fill sequences against physical memory on misses.
module cache_pipe_miss_stage #(
    parameter int WAYS      = 4,
    parameter int LINE_BITS = 256,
    parameter int ADDR_BITS = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid_i,
    input  logic                         req_read_i,
    input  logic                         req_write_i,
    input  logic [ADDR_BITS-1:0]         req_addr_i,
    input  logic [LINE_BITS-1:0]         req_wdata_i,
    input  logic [LINE_BITS/8-1:0]       req_wmask_i,
    input  logic                         hit_i,
    input  logic [$clog2(WAYS)-1:0]      hit_way_i,
    input  logic [$clog2(WAYS)-1:0]      victim_way_i,
    input  logic                         victim_dirty_i,
    input  logic [ADDR_BITS-1:0]         victim_addr_i,
    input  logic [LINE_BITS-1:0]         cache_line_i,
    input  logic                         stall_i,
    input  logic                         pmem_resp_i,
    input  logic [LINE_BITS-1:0]         pmem_rdata_i,
    output logic                         pmem_read_o,
    output logic                         pmem_write_o,
    output logic [ADDR_BITS-1:0]         pmem_addr_o,
    output logic [LINE_BITS-1:0]         pmem_wdata_o,
    output logic                         stall_o,
    output logic                         data_we_o,
    output logic [$clog2(WAYS)-1:0]      data_way_o,
    output logic [LINE_BITS-1:0]         data_line_o,
    output logic                         dirty_set_o,
    output logic                         lru_update_o,
    output logic [$clog2(WAYS)-1:0]      lru_way_o,
    output logic                         resp_o,
    output logic [LINE_BITS-1:0]         rdata_o
);

    localparam int WB  = $clog2(WAYS);
    localparam int MB  = LINE_BITS / 8;
    localparam int OFF = $clog2(MB);
    localparam logic [ADDR_BITS-1:0] OFF_MASK = ADDR_BITS'((1 << OFF) - 1);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, DONE} state_t;

    state_t                 state_q, state_d;
    logic                   valid_q, read_q, write_q, hit_q, victim_dirty_q, fired_q;
    logic [ADDR_BITS-1:0]   addr_q, victim_addr_q;
    logic [LINE_BITS-1:0]   wdata_q, line_q, fill_q;
    logic [MB-1:0]          wmask_q;
    logic [WB-1:0]          hit_way_q, victim_way_q;
    logic                   load, access, miss, hit_fire;

    function automatic logic [LINE_BITS-1:0] merge(input logic [LINE_BITS-1:0] base,
                                                   input logic [LINE_BITS-1:0] wdata,
                                                   input logic [MB-1:0]        mask);
        logic [LINE_BITS-1:0] res;
        res = base;
        for (int i = 0; i < MB; i++) begin
            if (mask[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

    // A request with neither read nor write set is a no-op; fired_q keeps a stalled hit from answering twice.
    assign load     = !stall_o && !stall_i;
    assign access   = valid_q && (read_q || write_q);
    assign miss     = access && !hit_q;
    assign hit_fire = (state_q == IDLE) && access && hit_q && !fired_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            valid_q        <= 1'b0;
            read_q         <= 1'b0;
            write_q        <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            wmask_q        <= '0;
            hit_q          <= 1'b0;
            hit_way_q      <= '0;
            victim_way_q   <= '0;
            victim_dirty_q <= 1'b0;
            victim_addr_q  <= '0;
            line_q         <= '0;
            fill_q         <= '0;
            fired_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                valid_q        <= req_valid_i;
                read_q         <= req_read_i;
                write_q        <= req_write_i;
                addr_q         <= req_addr_i;
                wdata_q        <= req_wdata_i;
                wmask_q        <= req_wmask_i;
                hit_q          <= hit_i;
                hit_way_q      <= hit_way_i;
                victim_way_q   <= victim_way_i;
                victim_dirty_q <= victim_dirty_i;
                victim_addr_q  <= victim_addr_i;
                line_q         <= cache_line_i;
                fired_q        <= 1'b0;
            end else begin
                if (state_q == DONE) valid_q <= 1'b0;
                if (hit_fire) fired_q <= 1'b1;
            end
            if (state_q == FILL && pmem_resp_i) fill_q <= pmem_rdata_i;
        end
    end

    always_comb begin
        state_d      = state_q;
        pmem_read_o  = 1'b0;
        pmem_write_o = 1'b0;
        pmem_addr_o  = '0;
        pmem_wdata_o = '0;
        stall_o      = 1'b0;
        data_we_o    = 1'b0;
        data_way_o   = '0;
        data_line_o  = '0;
        dirty_set_o  = 1'b0;
        lru_update_o = 1'b0;
        lru_way_o    = '0;
        resp_o       = 1'b0;
        rdata_o      = '0;
        case (state_q)
            IDLE: begin
                if (hit_fire) begin
                    resp_o       = 1'b1;
                    rdata_o      = line_q;
                    lru_update_o = 1'b1;
                    lru_way_o    = hit_way_q;
                    if (write_q) begin
                        data_we_o   = 1'b1;
                        data_way_o  = hit_way_q;
                        data_line_o = merge(line_q, wdata_q, wmask_q);
                        dirty_set_o = 1'b1;
                    end
                end else if (miss) begin
                    stall_o = 1'b1;
                    state_d = victim_dirty_q ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                stall_o      = 1'b1;
                pmem_write_o = 1'b1;
                pmem_addr_o  = victim_addr_q & ~OFF_MASK;
                pmem_wdata_o = line_q;
                if (pmem_resp_i) state_d = FILL;
            end
            FILL: begin
                stall_o     = 1'b1;
                pmem_read_o = 1'b1;
                pmem_addr_o = addr_q & ~OFF_MASK;
                if (pmem_resp_i) begin
                    data_we_o   = 1'b1;
                    data_way_o  = victim_way_q;
                    data_line_o = write_q ? merge(pmem_rdata_i, wdata_q, wmask_q) : pmem_rdata_i;
                    dirty_set_o = write_q;
                    state_d     = DONE;
                end
            end
            DONE: begin
                resp_o       = 1'b1;
                rdata_o      = fill_q;
                lru_update_o = 1'b1;
                lru_way_o    = victim_way_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_pipe_miss_stage.sv
// Directed bench for cache_pipe_miss_stage: hits, clean and dirty misses, reset mid-fill
// and stalled back-to-back hits, each checked against hand-computed values.
module tb_cache_pipe_miss_stage;

    localparam int LB = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid_i = 1'b0, req_read_i = 1'b0, req_write_i = 1'b0;
    logic [31:0]   req_addr_i = '0;
    logic [LB-1:0] req_wdata_i = '0;
    logic [31:0]   req_wmask_i = '0;
    logic          hit_i = 1'b0;
    logic [1:0]    hit_way_i = '0, victim_way_i = '0;
    logic          victim_dirty_i = 1'b0;
    logic [31:0]   victim_addr_i = '0;
    logic [LB-1:0] cache_line_i = '0;
    logic          stall_i = 1'b0, pmem_resp_i = 1'b0;
    logic [LB-1:0] pmem_rdata_i = '0;
    logic          pmem_read_o, pmem_write_o, stall_o, data_we_o, dirty_set_o, lru_update_o, resp_o;
    logic [31:0]   pmem_addr_o;
    logic [LB-1:0] pmem_wdata_o, data_line_o, rdata_o;
    logic [1:0]    data_way_o, lru_way_o;

    int checks = 0;
    int errors = 0;

    logic [LB-1:0] line_a5, line_ff, line_vic, line_fill, line_11, line_3c, line_x, line_y;

    cache_pipe_miss_stage dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_read_i(req_read_i), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wmask_i(req_wmask_i),
        .hit_i(hit_i), .hit_way_i(hit_way_i), .victim_way_i(victim_way_i),
        .victim_dirty_i(victim_dirty_i), .victim_addr_i(victim_addr_i),
        .cache_line_i(cache_line_i), .stall_i(stall_i),
        .pmem_resp_i(pmem_resp_i), .pmem_rdata_i(pmem_rdata_i),
        .pmem_read_o(pmem_read_o), .pmem_write_o(pmem_write_o), .pmem_addr_o(pmem_addr_o),
        .pmem_wdata_o(pmem_wdata_o), .stall_o(stall_o), .data_we_o(data_we_o),
        .data_way_o(data_way_o), .data_line_o(data_line_o), .dirty_set_o(dirty_set_o),
        .lru_update_o(lru_update_o), .lru_way_o(lru_way_o), .resp_o(resp_o), .rdata_o(rdata_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [LB-1:0] observed, input logic [LB-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [LB-1:0] wdata, input logic [31:0] wmask, input logic hit,
                                 input logic [1:0] hway, input logic [1:0] vway, input logic vdirty,
                                 input logic [31:0] vaddr, input logic [LB-1:0] line);
        req_valid_i    = valid;
        req_read_i     = rd;
        req_write_i    = wr;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        req_wmask_i    = wmask;
        hit_i          = hit;
        hit_way_i      = hway;
        victim_way_i   = vway;
        victim_dirty_i = vdirty;
        victim_addr_i  = vaddr;
        cache_line_i   = line;
    endtask

    task automatic bubble();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, '0, 32'h0, 1'b0, 2'd0, 2'd0, 1'b0, 32'h0, '0);
    endtask

    initial begin
        line_a5   = {32{8'hA5}};
        line_ff   = {32{8'hFF}};
        line_vic  = {8{32'h1234_5678}};
        line_fill = {8{32'hDEAD_BEEF}};
        line_11   = {32{8'h11}};
        line_3c   = {32{8'h3C}};
        line_x    = {16{16'hC0DE}};
        line_y    = {16{16'hBEEF}};

        // Reset: every output low.
        #1 rst = 1'b1;
        #19;
        checkOutput("rst_resp", resp_o, 0);
        checkOutput("rst_stall", stall_o, 0);
        checkOutput("rst_pmem_rd", pmem_read_o, 0);
        checkOutput("rst_pmem_wr", pmem_write_o, 0);
        checkOutput("rst_data_we", data_we_o, 0);
        checkOutput("rst_lru", lru_update_o, 0);
        checkOutput("rst_pmem_addr", pmem_addr_o, 0);
        #2 rst = 1'b0;

        // Read hit in way 2.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h100, '0, 32'h0, 1'b1, 2'd2, 2'd0, 1'b0, 32'h0, line_a5);
        tick();
        bubble();
        checkOutput("rhit_resp", resp_o, 1);
        checkOutput("rhit_rdata", rdata_o, line_a5);
        checkOutput("rhit_lru", lru_update_o, 1);
        checkOutput("rhit_lru_way", lru_way_o, 2);
        checkOutput("rhit_stall", stall_o, 0);
        checkOutput("rhit_pmem", {pmem_read_o, pmem_write_o}, 0);
        checkOutput("rhit_we", data_we_o, 0);

        // Write hit in way 1, low four bytes replaced.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h200, line_ff, 32'h0000_000F, 1'b1, 2'd1, 2'd0, 1'b0, 32'h0, line_a5);
        tick();
        bubble();
        checkOutput("whit_resp", resp_o, 1);
        checkOutput("whit_we", data_we_o, 1);
        checkOutput("whit_way", data_way_o, 1);
        checkOutput("whit_line", data_line_o, {{28{8'hA5}}, 32'hFFFF_FFFF});
        checkOutput("whit_dirty", dirty_set_o, 1);
        checkOutput("whit_lru_way", lru_way_o, 1);

        // Clean read miss at 0x1234, victim way 3, memory answers after 5 cycles.
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_1234, '0, 32'h0, 1'b0, 2'd0, 2'd3, 1'b0, 32'h0, line_a5);
        tick();
        bubble();
        checkOutput("cmiss_stall_idle", stall_o, 1);
        checkOutput("cmiss_no_resp", resp_o, 0);
        tick();
        checkOutput("cmiss_pmem_rd", pmem_read_o, 1);
        checkOutput("cmiss_pmem_wr", pmem_write_o, 0);
        checkOutput("cmiss_addr", pmem_addr_o, 32'h0000_1220);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("cmiss_rd_hold", pmem_read_o, 1);
            checkOutput("cmiss_addr_hold", pmem_addr_o, 32'h0000_1220);
            checkOutput("cmiss_stall_hold", stall_o, 1);
        end
        pmem_resp_i  = 1'b1;
        pmem_rdata_i = line_fill;
        #1;
        checkOutput("cmiss_we", data_we_o, 1);
        checkOutput("cmiss_way", data_way_o, 3);
        checkOutput("cmiss_line", data_line_o, line_fill);
        checkOutput("cmiss_dirty", dirty_set_o, 0);
        checkOutput("cmiss_resp_early", resp_o, 0);
        tick();
        pmem_resp_i  = 1'b0;
        pmem_rdata_i = '0;
        #1;
        checkOutput("cmiss_resp", resp_o, 1);
        checkOutput("cmiss_rdata", rdata_o, line_fill);
        checkOutput("cmiss_lru_way", lru_way_o, 3);
        checkOutput("cmiss_stall_rel", stall_o, 0);
        checkOutput("cmiss_pmem_rel", pmem_read_o, 0);
        tick();
        checkOutput("cmiss_after", resp_o, 0);

        // Dirty write miss: write-back of the victim, then fill merged with the top four bytes.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_2008, line_3c, 32'hF000_0000, 1'b0, 2'd0, 2'd0, 1'b1,
                      32'h8000_0040, line_vic);
        tick();
        bubble();
        checkOutput("dmiss_stall_idle", stall_o, 1);
        tick();
        checkOutput("dmiss_wb_wr", pmem_write_o, 1);
        checkOutput("dmiss_wb_rd", pmem_read_o, 0);
        checkOutput("dmiss_wb_addr", pmem_addr_o, 32'h8000_0040);
        checkOutput("dmiss_wb_data", pmem_wdata_o, line_vic);
        tick();
        checkOutput("dmiss_wb_hold", pmem_write_o, 1);
        pmem_resp_i = 1'b1;
        #1;
        checkOutput("dmiss_wb_no_we", data_we_o, 0);
        tick();
        pmem_resp_i = 1'b0;
        #1;
        checkOutput("dmiss_fill_rd", pmem_read_o, 1);
        checkOutput("dmiss_fill_wr", pmem_write_o, 0);
        checkOutput("dmiss_fill_addr", pmem_addr_o, 32'h0000_2000);
        tick();
        pmem_resp_i  = 1'b1;
        pmem_rdata_i = line_11;
        #1;
        checkOutput("dmiss_we", data_we_o, 1);
        checkOutput("dmiss_way", data_way_o, 0);
        checkOutput("dmiss_line", data_line_o, {{4{8'h3C}}, {28{8'h11}}});
        checkOutput("dmiss_dirty", dirty_set_o, 1);
        tick();
        pmem_resp_i  = 1'b0;
        pmem_rdata_i = '0;
        #1;
        checkOutput("dmiss_resp", resp_o, 1);
        checkOutput("dmiss_lru", lru_update_o, 1);
        checkOutput("dmiss_stall_rel", stall_o, 0);
        tick();

        // Reset asserted while a fill is outstanding.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_4000, '0, 32'h0, 1'b0, 2'd0, 2'd2, 1'b0, 32'h0, line_a5);
        tick();
        bubble();
        tick();
        checkOutput("rstm_in_fill", pmem_read_o, 1);
        #1 rst = 1'b1;
        pmem_resp_i  = 1'b1;
        pmem_rdata_i = line_fill;
        #1;
        checkOutput("rstm_pmem_drop", pmem_read_o, 0);
        checkOutput("rstm_no_we", data_we_o, 0);
        checkOutput("rstm_stall", stall_o, 0);
        #2 rst = 1'b0;
        tick();
        checkOutput("rstm_idle_rd", pmem_read_o, 0);
        checkOutput("rstm_idle_we", data_we_o, 0);
        checkOutput("rstm_idle_resp", resp_o, 0);
        pmem_resp_i  = 1'b0;
        pmem_rdata_i = '0;

        // Back-to-back read hits with stall_i held for three stage cycles.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h300, '0, 32'h0, 1'b1, 2'd1, 2'd0, 1'b0, 32'h0, line_x);
        tick();
        stall_i = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h400, '0, 32'h0, 1'b1, 2'd2, 2'd0, 1'b0, 32'h0, line_y);
        checkOutput("stl_a_resp", resp_o, 1);
        checkOutput("stl_a_rdata", rdata_o, line_x);
        checkOutput("stl_a_lru_way", lru_way_o, 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("stl_a_no_resp", resp_o, 0);
            checkOutput("stl_a_no_lru", lru_update_o, 0);
        end
        stall_i = 1'b0;
        tick();
        bubble();
        checkOutput("stl_b_resp", resp_o, 1);
        checkOutput("stl_b_rdata", rdata_o, line_y);
        checkOutput("stl_b_lru_way", lru_way_o, 2);
        tick();
        checkOutput("stl_b_once", resp_o, 0);
        checkOutput("stl_b_lru_once", lru_update_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
